// File: rtl/huff_pkg.sv
// huff_pkg: shared constants, table-entry field helpers and FSM encoding
// for the bit-serial Huffman decoder.  Rev 1.0
`default_nettype none

package huff_pkg;
  localparam int NUM_SYM = 10;
  localparam int CODE_W  = 13;
  localparam int LEN_W   = 4;
  localparam int MAX_LEN = 9;
  localparam int CNT_W   = 16;
  localparam int IDX_W   = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_HOLD = 3'd3,
    S_FIN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  typedef logic [NUM_SYM-1:0][CODE_W-1:0] table_t;

  function automatic logic [LEN_W-1:0] entry_len(input logic [CODE_W-1:0] e);
    return e[CODE_W-1 -: LEN_W];
  endfunction

  function automatic logic [MAX_LEN-1:0] entry_code(input logic [CODE_W-1:0] e);
    return e[MAX_LEN-1:0];
  endfunction
endpackage

`default_nettype wire

// File: rtl/huff_match.sv
// huff_match: combinational table lookup; reports a hit and the lowest
// index whose length equals i_len and whose low i_len bits equal i_cand.  Rev 1.0
`default_nettype none

module huff_match
  import huff_pkg::*;
(
  input  table_t             i_table,
  input  logic [MAX_LEN-1:0] i_cand,
  input  logic [LEN_W-1:0]   i_len,
  output logic               o_hit,
  output logic [IDX_W-1:0]   o_idx
);
  logic [MAX_LEN-1:0] w_mask;
  logic [NUM_SYM-1:0] w_match;

  assign w_mask = ~({MAX_LEN{1'b1}} << i_len);

  always_comb begin
    w_match = '0;
    for (int i = 0; i < NUM_SYM; i++) begin
      w_match[i] = (i_len != '0) && (entry_len(i_table[i]) == i_len) &&
                   ((entry_code(i_table[i]) & w_mask) == (i_cand & w_mask));
    end
  end

  // Descending scan so the lowest matching index wins.
  always_comb begin
    o_hit = |w_match;
    o_idx = '0;
    for (int i = NUM_SYM - 1; i >= 0; i--) begin
      if (w_match[i]) o_idx = IDX_W'(i);
    end
  end
endmodule

`default_nettype wire

// File: rtl/huffman_decoder.sv
// huffman_decoder: bit-serial MSB-first Huffman decoder over a latched 10-entry
// code table. HUFF_DEC_SKID_EN adds a 1-entry symbol skid buffer.  Rev 1.0
`default_nettype none

module huffman_decoder
  import huff_pkg::*;
(
  input  logic               Clk_in,
  input  logic               n_Rst,
  input  logic               Start_decode,
  input  logic [CODE_W-1:0]  Code0,
  input  logic [CODE_W-1:0]  Code1,
  input  logic [CODE_W-1:0]  Code2,
  input  logic [CODE_W-1:0]  Code3,
  input  logic [CODE_W-1:0]  Code4,
  input  logic [CODE_W-1:0]  Code5,
  input  logic [CODE_W-1:0]  Code6,
  input  logic [CODE_W-1:0]  Code7,
  input  logic [CODE_W-1:0]  Code8,
  input  logic [CODE_W-1:0]  Code9,
  input  logic [CNT_W-1:0]   Num_sym,
  input  logic               Bit_in,
  input  logic               Bit_valid,
  output logic               Bit_ready,
  output logic [IDX_W-1:0]   Sym_out,
  output logic               Sym_valid,
  input  logic               Sym_ready,
  output logic               Busy,
  output logic               Done,
  output logic               Decode_err,
  output logic [CNT_W-1:0]   Sym_count
);
`ifdef HUFF_DEC_SKID_EN
  localparam bit SKID_EN = 1'b1;
`else
  localparam bit SKID_EN = 1'b0;
`endif

  state_t             r_state, w_next;
  table_t             r_table, w_codes;
  logic [CNT_W-1:0]   r_num, r_count, r_dec;
  logic [MAX_LEN-2:0] r_acc;
  logic [LEN_W-1:0]   r_cnt, w_n;
  logic [MAX_LEN-1:0] w_cand;
  logic               w_hit;
  logic [IDX_W-1:0]   w_idx;
  logic               r_sym_valid, r_skid_valid, r_err;
  logic [IDX_W-1:0]   r_sym_out, r_skid;
  logic               w_take, w_push, w_pop, w_err_hit, w_last_dec, w_last_pop;

  assign w_codes    = {Code9, Code8, Code7, Code6, Code5, Code4, Code3, Code2, Code1, Code0};
  assign w_cand     = {r_acc, Bit_in};
  assign w_n        = r_cnt + 1'b1;
  assign Bit_ready  = (r_state == S_RUN) && !(r_sym_valid && r_skid_valid);
  assign w_take     = Bit_ready && Bit_valid;
  assign w_push     = w_take && w_hit;
  assign w_pop      = r_sym_valid && Sym_ready;
  assign w_err_hit  = w_take && !w_hit && (w_n == LEN_W'(MAX_LEN));
  assign w_last_dec = (r_dec + 1'b1) == r_num;
  assign w_last_pop = (r_count + 1'b1) == r_num;

  assign Sym_out    = r_sym_out;
  assign Sym_valid  = r_sym_valid;
  assign Decode_err = r_err;
  assign Sym_count  = r_count;

  huff_match u_match (
    .i_table (r_table),
    .i_cand  (w_cand),
    .i_len   (w_n),
    .o_hit   (w_hit),
    .o_idx   (w_idx)
  );

  always_comb begin
    w_next = r_state;
    Busy   = 1'b0;
    Done   = 1'b0;
    case (r_state)
      S_IDLE: if (Start_decode) w_next = S_LOAD;
      S_LOAD: begin
        Busy   = 1'b1;
        w_next = (Num_sym == '0) ? S_FIN : S_RUN;
      end
      S_RUN: begin
        Busy = 1'b1;
        // With the skid buffer, keep decoding until every symbol is decoded.
        if (w_push)         w_next = (!SKID_EN || w_last_dec) ? S_HOLD : S_RUN;
        else if (w_err_hit) w_next = S_ERR;
      end
      S_HOLD: begin
        Busy = 1'b1;
        if (w_pop) begin
          if (w_last_pop)    w_next = S_FIN;
          else if (!SKID_EN) w_next = S_RUN;
        end
      end
      S_FIN: begin
        Done   = 1'b1;
        w_next = S_IDLE;
      end
      S_ERR:   if (Start_decode) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_in or negedge n_Rst) begin
    if (!n_Rst) begin
      r_state      <= S_IDLE;
      r_table      <= '0;
      r_num        <= '0;
      r_count      <= '0;
      r_dec        <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_sym_valid  <= 1'b0;
      r_sym_out    <= '0;
      r_skid_valid <= 1'b0;
      r_skid       <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_LOAD) begin
        r_table      <= w_codes;
        r_num        <= Num_sym;
        r_count      <= '0;
        r_dec        <= '0;
        r_acc        <= '0;
        r_cnt        <= '0;
        r_err        <= 1'b0;
        r_sym_valid  <= 1'b0;
        r_skid_valid <= 1'b0;
      end else begin
        if (w_take) begin
          if (w_hit) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_dec <= r_dec + 1'b1;
          end else if (w_err_hit) begin
            r_err <= 1'b1;
          end else begin
            r_acc <= w_cand[MAX_LEN-2:0];
            r_cnt <= w_n;
          end
        end
        if (w_pop) r_count <= r_count + 1'b1;
        // Output register refills from the skid entry first to keep order.
        if (w_pop) begin
          if (r_skid_valid) begin
            r_sym_out    <= r_skid;
            r_skid_valid <= w_push;
            if (w_push) r_skid <= w_idx;
          end else begin
            r_sym_valid <= w_push;
            if (w_push) r_sym_out <= w_idx;
          end
        end else if (w_push) begin
          if (!r_sym_valid) begin
            r_sym_valid <= 1'b1;
            r_sym_out   <= w_idx;
          end else begin
            r_skid_valid <= 1'b1;
            r_skid       <= w_idx;
          end
        end
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_huffman_decoder.sv
// tb_huffman_decoder: self-checking bench; expected symbols come from encoding
// chosen symbols with the table, then comparing against what the DUT delivers.
`default_nettype none
`timescale 1ns/1ps

module tb_huffman_decoder;
  logic        Clk_in = 1'b0;
  logic        n_Rst = 1'b0;
  logic        Start_decode = 1'b0;
  logic        Bit_in = 1'b0;
  logic        Bit_valid = 1'b0;
  logic        Sym_ready = 1'b0;
  logic [15:0] Num_sym = '0;
  logic [12:0] tbl [10];
  logic        Bit_ready, Sym_valid, Busy, Done, Decode_err;
  logic [3:0]  Sym_out;
  logic [15:0] Sym_count;

  int vectors = 0;
  int miscompares = 0;
  bit tx_bits[$];
  int rx_syms[$];
  int exp_syms[$];
  int done_cnt, hold_ready_seen, hold_unstable, lat_bad;
  int cyc = 0;
  int last_bit_cyc = -100;
  bit prev_valid = 1'b0;

  huffman_decoder dut (
    .Clk_in(Clk_in), .n_Rst(n_Rst), .Start_decode(Start_decode),
    .Code0(tbl[0]), .Code1(tbl[1]), .Code2(tbl[2]), .Code3(tbl[3]), .Code4(tbl[4]),
    .Code5(tbl[5]), .Code6(tbl[6]), .Code7(tbl[7]), .Code8(tbl[8]), .Code9(tbl[9]),
    .Num_sym(Num_sym), .Bit_in(Bit_in), .Bit_valid(Bit_valid), .Bit_ready(Bit_ready),
    .Sym_out(Sym_out), .Sym_valid(Sym_valid), .Sym_ready(Sym_ready), .Busy(Busy),
    .Done(Done), .Decode_err(Decode_err), .Sym_count(Sym_count)
  );

  always #5 Clk_in = ~Clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void clear_table();
    for (int i = 0; i < 10; i++) tbl[i] = '0;
  endfunction

  function automatic void set_basic();
    clear_table();
    tbl[0] = 13'h0200;
    tbl[1] = 13'h0402;
    tbl[2] = 13'h0606;
    tbl[3] = 13'h0607;
  endfunction

  // Codeword of rank r: r ones then a zero (r<9); rank 9 is nine ones.
  function automatic logic [12:0] rank_entry(input int r);
    logic [3:0] l;
    logic [8:0] v;
    if (r == 9) begin
      l = 4'd9;
      v = 9'h1FF;
    end else begin
      l = 4'(r + 1);
      v = 9'((1 << (r + 1)) - 2);
    end
    return {l, v};
  endfunction

  function automatic void push_code(input logic [12:0] e);
    int len;
    len = int'(e[12:9]);
    for (int b = len - 1; b >= 0; b--) tx_bits.push_back(e[b]);
  endfunction

  function automatic void push_bits(input int n, input bit v);
    for (int i = 0; i < n; i++) tx_bits.push_back(v);
  endfunction

  task automatic start(input int num);
    @(negedge Clk_in);
    Num_sym      = 16'(num);
    Start_decode = 1'b1;
    Bit_valid    = 1'b0;
    @(negedge Clk_in);
    Start_decode = 1'b0;
    prev_valid   = 1'b0;
    last_bit_cyc = -100;
    rx_syms.delete();
  endtask

  // Per-cycle stimulus and observation at the falling edge; stops on Done or budget.
  task automatic drive(input int budget, input int rdy_pct, input int val_pct,
                       input int hold_idx, input int hold_len);
    int         held;
    logic [3:0] held_val;
    held     = 0;
    held_val = '0;
    done_cnt = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge Clk_in);
      cyc++;
      if (Done) begin
        done_cnt++;
        Bit_valid = 1'b0;
        break;
      end
      if (Sym_valid && !prev_valid && (cyc - last_bit_cyc) != 1) lat_bad++;
      prev_valid = Sym_valid;
      Bit_valid  = (tx_bits.size() > 0) && ($urandom_range(99) < val_pct);
      Bit_in     = (tx_bits.size() > 0) ? tx_bits[0] : 1'b0;
      if (Sym_valid && rx_syms.size() == hold_idx && held < hold_len) begin
        if (held == 0) held_val = Sym_out;
        else if (Sym_out !== held_val) hold_unstable++;
        if (Bit_ready) hold_ready_seen++;
        Sym_ready = 1'b0;
        held++;
      end else begin
        Sym_ready = ($urandom_range(99) < rdy_pct);
      end
      if (Bit_valid && Bit_ready) begin
        void'(tx_bits.pop_front());
        last_bit_cyc = cyc;
      end
      if (Sym_valid && Sym_ready) rx_syms.push_back(int'(Sym_out));
    end
    Bit_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({Bit_ready, Sym_valid, Busy, Done, Decode_err, Sym_out} !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 0", {Bit_ready, Sym_valid, Busy, Done, Decode_err, Sym_out});
    end
    vectors++;
    if (Sym_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_count: got %0d expected 0", Sym_count);
    end
    @(negedge Clk_in);
    n_Rst = 1'b1;
    @(negedge Clk_in);
    vectors++;
    if (Bit_ready !== 1'b0 || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_state: Bit_ready=%b Busy=%b expected 0 0", Bit_ready, Busy);
    end
  endtask

  task automatic test_basic();
    set_basic();
    start(4);
    tx_bits.delete();
    push_bits(1, 0); push_bits(1, 1); push_bits(1, 0);
    push_bits(2, 1); push_bits(1, 0); push_bits(3, 1);
    lat_bad = 0;
    drive(100, 100, 100, -1, 0);
    vectors++;
    if (rx_syms.size() != 4) begin
      miscompares++;
      $display("FAIL basic_count: got %0d symbols expected 4", rx_syms.size());
    end
    for (int i = 0; i < 4 && i < rx_syms.size(); i++) begin
      vectors++;
      if (rx_syms[i] != i) begin
        miscompares++;
        $display("FAIL basic_sym%0d: got %0d expected %0d", i, rx_syms[i], i);
      end
    end
    vectors++;
    if (lat_bad != 0) begin
      miscompares++;
      $display("FAIL basic_latency: %0d late symbols, expected 0", lat_bad);
    end
    vectors++;
    if (done_cnt != 1 || Sym_count !== 16'd4) begin
      miscompares++;
      $display("FAIL basic_done: done=%0d Sym_count=%0d expected 1 4", done_cnt, Sym_count);
    end
    @(negedge Clk_in);
    vectors++;
    if (Done !== 1'b0 || Busy !== 1'b0 || Sym_count !== 16'd4) begin
      miscompares++;
      $display("FAIL basic_after: Done=%b Busy=%b Sym_count=%0d expected 0 0 4", Done, Busy, Sym_count);
    end
  endtask

  task automatic test_backpressure();
    set_basic();
    start(4);
    tx_bits.delete();
    push_bits(1, 0); push_bits(1, 1); push_bits(1, 0);
    push_bits(2, 1); push_bits(1, 0); push_bits(3, 1);
    hold_ready_seen = 0;
    hold_unstable   = 0;
    drive(100, 100, 100, 1, 5);
    vectors++;
    if (hold_ready_seen != 0 || hold_unstable != 0) begin
      miscompares++;
      $display("FAIL bp_hold: ready_cycles=%0d unstable=%0d expected 0 0", hold_ready_seen, hold_unstable);
    end
    vectors++;
    if (rx_syms.size() != 4 || tx_bits.size() != 0 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL bp_stream: syms=%0d bits_left=%0d done=%0d expected 4 0 1", rx_syms.size(), tx_bits.size(), done_cnt);
    end
    for (int i = 0; i < rx_syms.size(); i++) begin
      vectors++;
      if (rx_syms[i] != i) begin
        miscompares++;
        $display("FAIL bp_sym%0d: got %0d expected %0d", i, rx_syms[i], i);
      end
    end
  endtask

  task automatic test_error();
    clear_table();
    tbl[0] = 13'h0200;
    start(2);
    tx_bits.delete();
    push_bits(8, 1);
    drive(20, 100, 100, -1, 0);
    vectors++;
    if (Decode_err !== 1'b0 || Busy !== 1'b1 || tx_bits.size() != 0) begin
      miscompares++;
      $display("FAIL err_8bits: err=%b busy=%b bits_left=%0d expected 0 1 0", Decode_err, Busy, tx_bits.size());
    end
    push_bits(1, 1);
    drive(5, 100, 100, -1, 0);
    vectors++;
    if (Decode_err !== 1'b1 || Bit_ready !== 1'b0 || Busy !== 1'b0 || done_cnt != 0) begin
      miscompares++;
      $display("FAIL err_9bits: err=%b ready=%b busy=%b done=%0d expected 1 0 0 0", Decode_err, Bit_ready, Busy, done_cnt);
    end
    set_basic();
    start(1);
    @(negedge Clk_in);
    vectors++;
    if (Decode_err !== 1'b0 || Bit_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL err_restart: err=%b ready=%b expected 0 1", Decode_err, Bit_ready);
    end
    tx_bits.delete();
    push_bits(1, 0);
    drive(50, 100, 100, -1, 0);
    vectors++;
    if (rx_syms.size() != 1 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL err_recover: syms=%0d done=%0d expected 1 1", rx_syms.size(), done_cnt);
    end
  endtask

  task automatic test_zero();
    int ready_seen;
    int done_at;
    set_basic();
    ready_seen = 0;
    done_at    = -1;
    start(0);
    for (int k = 0; k < 4; k++) begin
      if (Bit_ready || Sym_valid) ready_seen++;
      if (Done && done_at < 0) done_at = k;
      @(negedge Clk_in);
    end
    vectors++;
    if (done_at != 1) begin
      miscompares++;
      $display("FAIL zero_done: Done at %0d expected 1 (two cycles after Start)", done_at);
    end
    vectors++;
    if (ready_seen != 0 || Sym_count !== 16'd0) begin
      miscompares++;
      $display("FAIL zero_quiet: ready/valid cycles=%0d Sym_count=%0d expected 0 0", ready_seen, Sym_count);
    end
  endtask

  task automatic test_async_reset();
    set_basic();
    start(4);
    tx_bits.delete();
    push_bits(1, 0); push_bits(1, 1); push_bits(1, 0); push_bits(2, 1);
    drive(8, 100, 100, -1, 0);
    vectors++;
    if (Sym_count !== 16'd2 || Bit_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_pre: Sym_count=%0d ready=%b expected 2 1", Sym_count, Bit_ready);
    end
    #2;
    n_Rst = 1'b0;
    #1;
    vectors++;
    if ({Bit_ready, Sym_valid, Busy, Done, Decode_err, Sym_out} !== 9'd0 || Sym_count !== 16'd0) begin
      miscompares++;
      $display("FAIL arst_outputs: flags=%b Sym_count=%0d expected 0 0",
               {Bit_ready, Sym_valid, Busy, Done, Decode_err, Sym_out}, Sym_count);
    end
    @(negedge Clk_in);
    n_Rst = 1'b1;
    start(1);
    tx_bits.delete();
    push_bits(1, 0);
    drive(50, 100, 100, -1, 0);
    vectors++;
    if (rx_syms.size() != 1 || done_cnt != 1 || (rx_syms.size() == 1 && rx_syms[0] != 0)) begin
      miscompares++;
      $display("FAIL arst_restart: syms=%0d done=%0d first=%0d expected 1 1 0",
               rx_syms.size(), done_cnt, (rx_syms.size() > 0) ? rx_syms[0] : -1);
    end
  endtask

  task automatic test_random();
    int perm[10];
    int num, j, t, hidx;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 10; i++) perm[i] = i;
      for (int i = 9; i > 0; i--) begin
        j = $urandom_range(i);
        t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int i = 0; i < 10; i++) tbl[i] = rank_entry(perm[i]);
      num = $urandom_range(16, 1);
      exp_syms.delete();
      tx_bits.delete();
      for (int i = 0; i < num; i++) begin
        exp_syms.push_back($urandom_range(9));
        push_code(tbl[exp_syms[i]]);
      end
      start(num);
      hold_ready_seen = 0;
      hold_unstable   = 0;
      hidx = $urandom_range(num - 1);
      drive(3000, 60, 70, hidx, 3);
      vectors++;
      if (rx_syms.size() != num || done_cnt != 1 || Sym_count !== 16'(num)) begin
        miscompares++;
        $display("FAIL rand%0d_len: syms=%0d done=%0d Sym_count=%0d expected %0d 1 %0d",
                 it, rx_syms.size(), done_cnt, Sym_count, num, num);
      end
      vectors++;
      if (hold_ready_seen != 0 || hold_unstable != 0 || tx_bits.size() != 0) begin
        miscompares++;
        $display("FAIL rand%0d_hold: ready_cycles=%0d unstable=%0d bits_left=%0d expected 0 0 0",
                 it, hold_ready_seen, hold_unstable, tx_bits.size());
      end
      for (int i = 0; i < num && i < rx_syms.size(); i++) begin
        vectors++;
        if (rx_syms[i] != exp_syms[i]) begin
          miscompares++;
          $display("FAIL rand%0d_sym%0d: got %0d expected %0d", it, i, rx_syms[i], exp_syms[i]);
        end
      end
    end
  endtask

  initial begin
    clear_table();
    test_reset();
    test_basic();
    test_backpressure();
    test_error();
    test_zero();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

`default_nettype wire
